// File: rtl/sdram_port_arbiter.sv
// Two-port burst arbiter in front of a full-page SDRAM controller: camera writes and
// display reads take turns, with a read-priority policy bounded by a starvation limit.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 16,
  parameter int BURST_LEN    = 512,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_grant,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_data_rd,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              rd_done,
  output logic              c_rw,
  output logic              c_rw_en,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_f2s_data,
  input  logic              c_f2s_data_valid,
  input  logic [DATA_W-1:0] c_s2f_data,
  input  logic              c_s2f_data_valid,
  input  logic              c_ready,
  output logic              proto_err
);
  localparam int BEAT_W   = $clog2(BURST_LEN) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 2);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, BURST, WAIT_READY} state_t;

  state_t              r_state;
  logic                r_own_wr;
  logic                r_first;
  logic                r_c_rw;
  logic                r_c_rw_en;
  logic [ADDR_W-1:0]   r_c_addr;
  logic                r_wr_grant;
  logic                r_rd_grant;
  logic                r_wr_done;
  logic                r_rd_done;
  logic                r_proto_err;
  logic                r_rd_data_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [2:0]          r_wait_cnt;

  logic w_pick_wr;
  logic w_in_burst;
  logic w_wr_beat;
  logic w_rd_beat;
  logic w_last_beat;
  logic w_bad_strobe;

  always_comb begin
    w_pick_wr    = wr_req && (!rd_req || (r_starve_cnt >= STARVE_W'(STARVE_LIMIT)));
    w_in_burst   = (r_state == BURST);
    w_wr_beat    = w_in_burst && r_own_wr && c_f2s_data_valid;
    w_rd_beat    = w_in_burst && !r_own_wr && c_s2f_data_valid;
    w_last_beat  = (r_beat_cnt == BEAT_W'(BURST_LEN - 1));
    // Wrong-direction strobes in a burst, or any strobe after the last beat, are dropped.
    w_bad_strobe = (w_in_burst && (r_own_wr ? c_s2f_data_valid : c_f2s_data_valid)) ||
                   ((r_state == WAIT_READY) && (c_f2s_data_valid || c_s2f_data_valid));
  end

  assign wr_data_rd    = w_wr_beat;
  assign c_f2s_data    = (w_in_burst && r_own_wr) ? wr_data : '0;
  assign wr_grant      = r_wr_grant;
  assign rd_grant      = r_rd_grant;
  assign wr_done       = r_wr_done;
  assign rd_done       = r_rd_done;
  assign rd_data       = r_rd_data;
  assign rd_data_valid = r_rd_data_valid;
  assign c_rw          = r_c_rw;
  assign c_rw_en       = r_c_rw_en;
  assign c_addr        = r_c_addr;
  assign proto_err     = r_proto_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_own_wr        <= 1'b0;
      r_first         <= 1'b0;
      r_c_rw          <= 1'b0;
      r_c_rw_en       <= 1'b0;
      r_c_addr        <= '0;
      r_wr_grant      <= 1'b0;
      r_rd_grant      <= 1'b0;
      r_wr_done       <= 1'b0;
      r_rd_done       <= 1'b0;
      r_proto_err     <= 1'b0;
      r_rd_data_valid <= 1'b0;
      r_rd_data       <= '0;
      r_beat_cnt      <= '0;
      r_starve_cnt    <= '0;
      r_wait_cnt      <= '0;
    end else begin
      r_c_rw_en       <= 1'b0;
      r_wr_grant      <= 1'b0;
      r_rd_grant      <= 1'b0;
      r_wr_done       <= 1'b0;
      r_rd_done       <= 1'b0;
      r_rd_data_valid <= w_rd_beat;
      if (w_rd_beat) r_rd_data <= c_s2f_data;
      if (w_bad_strobe) r_proto_err <= 1'b1;
      unique case (r_state)
        IDLE: if (c_ready && (wr_req || rd_req)) begin
          r_own_wr <= w_pick_wr;
          r_c_rw   <= !w_pick_wr;
          r_c_addr <= w_pick_wr ? wr_addr : rd_addr;
          r_first  <= 1'b1;
          r_state  <= ISSUE;
        end
        ISSUE: begin
          // r_first separates the real grant from a timeout re-issue of c_rw_en.
          r_c_rw_en  <= 1'b1;
          r_wait_cnt <= '0;
          r_first    <= 1'b0;
          r_state    <= WAIT_BUSY;
          if (r_first) begin
            if (r_own_wr) begin
              r_wr_grant   <= 1'b1;
              r_starve_cnt <= '0;
            end else begin
              r_rd_grant <= 1'b1;
              if (wr_req && (r_starve_cnt < STARVE_W'(STARVE_LIMIT + 1)))
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
          end
        end
        WAIT_BUSY: begin
          if (!c_ready) begin
            r_state <= BURST;
          end else if (r_wait_cnt == 3'd7) begin
            r_proto_err <= 1'b1;
            r_state     <= ISSUE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end
        BURST: if (w_wr_beat || w_rd_beat) begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
          if (w_last_beat) r_state <= WAIT_READY;
        end
        WAIT_READY: if (c_ready) begin
          r_wr_done  <= r_own_wr;
          r_rd_done  <= !r_own_wr;
          r_beat_cnt <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single full-page-burst SDRAM controller between two requesters: the camera write path (pixel FIFO → SDRAM) and the display read path (SDRAM → line FIFO).
- Takes whole 512-word row-burst requests, grants one at a time, and issues the controller's rw/rw_en/addr handshake.
- Steers the burst data strobes to the owning port and reports burst completion.
- Sits between the capture/display FIFOs and the SDRAM controller.

Parameters:
- ADDR_W, 15, row+bank address width ({row[12:0], bank[1:0]}).
- DATA_W, 16, SDRAM word width.
- BURST_LEN, 512, data strobes per burst (full page).
- STARVE_LIMIT, 2, consecutive read grants allowed while a write is pending.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  1  write burst request (level, held until wr_grant).
- wr_addr  in  ADDR_W  write row/bank; sampled on the grant cycle.
- wr_grant  out  1  one-cycle pulse: write request accepted.
- wr_data  in  DATA_W  write word; first-word-fall-through from the capture FIFO.
- wr_data_rd  out  1  pop strobe to the capture FIFO (combinational).
- wr_done  out  1  one-cycle pulse: write burst complete.
- rd_req  in  1  read burst request (level, held until rd_grant).
- rd_addr  in  ADDR_W  read row/bank; sampled on the grant cycle.
- rd_grant  out  1  one-cycle pulse: read request accepted.
- rd_data  out  DATA_W  read word to the line FIFO.
- rd_data_valid  out  1  write strobe to the line FIFO.
- rd_done  out  1  one-cycle pulse: read burst complete.
- c_rw  out  1  to controller: 1=read, 0=write.
- c_rw_en  out  1  to controller: start request.
- c_addr  out  ADDR_W  to controller address.
- c_f2s_data  out  DATA_W  to controller write data.
- c_f2s_data_valid  in  1  controller consuming a write word this cycle.
- c_s2f_data  in  DATA_W  controller read data.
- c_s2f_data_valid  in  1  controller read data valid.
- c_ready  in  1  controller idle and able to accept a request.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: state=IDLE; all outputs 0 (c_addr=0, c_rw=0, proto_err=0); starve_cnt=0; beat_cnt=0. Reset mid-burst abandons the burst. The SDRAM controller must be reset in the same cycle.
- FSM states: IDLE, ISSUE, WAIT_BUSY, BURST, WAIT_READY.
- IDLE:
  - When c_ready=1 and any req=1, select the owner:
    - only one request pending → that port;
    - both pending → read, unless starve_cnt==STARVE_LIMIT, then write.
  - Register owner, c_rw and c_addr (from the owner's addr). Go to ISSUE.
- ISSUE (1 cycle):
  - c_rw_en=1; owner's grant=1. c_rw and c_addr are held stable from this cycle until the next grant.
  - starve_cnt: +1 on a read grant while wr_req=1; 0 on a write grant.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - c_ready=0 → BURST.
  - c_ready still 1 after 8 cycles → set proto_err and re-enter ISSUE (re-pulse c_rw_en, no second grant).
- BURST, write owner:
  - c_f2s_data=wr_data (combinational).
  - wr_data_rd = c_f2s_data_valid (combinational, same cycle).
  - Each strobe increments beat_cnt.
- BURST, read owner:
  - rd_data and rd_data_valid are c_s2f_data/c_s2f_data_valid registered by one cycle.
  - Each valid increments beat_cnt.
- Strobe steering: strobes are routed only to the owner. The non-owner's strobe outputs are 0 in all states. A strobe of the wrong type (e.g. c_s2f_data_valid during a write) sets proto_err and is dropped.
- Burst end: when beat_cnt reaches BURST_LEN, go to WAIT_READY. Any further strobe before c_ready=1 sets proto_err and is not forwarded.
- WAIT_READY: on c_ready=1, pulse the owner's done for 1 cycle, clear beat_cnt, return to IDLE. No new grant is issued in the done cycle, so the next issue comes at least 1 cycle later.
- Latency: req with c_ready=1 in IDLE → grant and c_rw_en 2 cycles later. Last read beat → rd_data_valid 1 cycle later; rd_done follows after the controller returns ready.
- beat_cnt width is clog2(BURST_LEN)+1 and never wraps.
- proto_err clears only on rst.
- c_rw_en is asserted only in ISSUE, so never more than 1 consecutive cycle.
- Requests dropped before grant are simply not served; no error is flagged.

Test Plan:
- Single write: wr_req=1, wr_addr=15'h0123, controller model ready → c_rw_en pulses once with c_rw=0, c_addr=0x0123, wr_grant the same cycle; 512 wr_data_rd pulses equal to c_f2s_data_valid; wr_done once; proto_err=0.
- Single read: rd_req, rd_addr=0x7FFC, model returns 0..511 → rd_data sequence 0..511 with exactly 512 rd_data_valid, each one cycle after the controller strobe; rd_done once.
- Contention: rd_req and wr_req held high together, STARVE_LIMIT=2 → grant order R,R,W,R,R,W; the write is never starved beyond 2 reads.
- Controller not ready: c_ready=0 for 100 cycles with requests pending → no c_rw_en and no grant until c_ready=1, then grant after 2 cycles.
- Protocol errors: model emits 513 read strobes → 512 forwarded, proto_err=1. Model leaves c_ready=1 after c_rw_en → proto_err=1 after 8 cycles and c_rw_en re-pulses.
- Reset mid-burst: assert rst at beat 200 of a write → next cycle all outputs 0, state IDLE; a subsequent read completes normally with 512 beats.
